cpu_run_ctrl: RTL

//  Run/step/breakpoint sequencer for the single-cycle core on the FPGA board.

---
 rtl/cpu_run_ctrl_pkg.sv | 35 +++
 rtl/cpu_run_ctrl_btn_debounce.sv | 77 +++++++
 rtl/cpu_run_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/cpu_run_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cpu_run_ctrl_pkg
//   Shared definitions for the run/step/breakpoint sequencer: the board mode
//   codes, the FSM state codes reported on oState, and the pulse-counter
//   width plus its wrapping increment helper.
//   Optional feature macro used by the slice: RUN_CYCLE_CNT_EN.
// -----------------------------------------------------------------------------
package cpu_run_ctrl_pkg;

  // Switch setting from the board (11 is reserved and behaves as HALT)
  typedef enum logic [1:0] {
    MODE_HALT = 2'b00,
    MODE_RUN  = 2'b01,
    MODE_STEP = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  // Sequencer state, encoded exactly as presented on oState
  typedef enum logic [1:0] {
    ST_HALT = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10,
    ST_BRK  = 2'b11
  } state_e;

  localparam int CYCLE_CNT_W = 32;

  // Pulse counter increment; rolls over from all-ones to zero
  function automatic logic [CYCLE_CNT_W-1:0] cycleCntIncr(
    input logic [CYCLE_CNT_W-1:0] cnt
  );
    return cnt + 32'd1;
  endfunction

endpackage

// File: rtl/cpu_run_ctrl_btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
//   Two-flop synchroniser followed by a stability counter for a bouncing,
//   asynchronous push-button. The debounced level only changes after DEB_N
//   consecutive synchronised samples that all differ from it; a one-cycle
//   press pulse marks each rising change of the debounced level.
// Ports
//   iClk    in  1  clock
//   iRst_n  in  1  asynchronous active-low reset
//   iBtn    in  1  raw button, active-high
//   oPress  out 1  registered one-cycle pulse on debounced rising edge
// -----------------------------------------------------------------------------
module btn_debounce
  import cpu_run_ctrl_pkg::*;
#(
  parameter int DEB_N = 20_000
) (
  input  logic iClk,
  input  logic iRst_n,
  input  logic iBtn,
  output logic oPress
);

  localparam int CNT_W = (DEB_N > 1) ? $clog2(DEB_N) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEB_N - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic             sync1R;
  logic             sync2R;
  logic             levelR;
  logic             pressR;
  logic [CNT_W-1:0] cntR;
  logic             differS;
  logic             flipS;

  // Sample differs from the debounced level; flip on the DEB_N-th such sample
  always_comb begin
    differS = (sync2R != levelR);
    flipS   = differS && (cntR == CNT_MAX);
  end

  // Two-flop synchroniser for the asynchronous button input
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      sync1R <= 1'b0;
      sync2R <= 1'b0;
    end else begin
      sync1R <= iBtn;
      sync2R <= sync1R;
    end
  end

  // Stability counter, debounced level and press pulse
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      cntR   <= CNT_ZERO;
      levelR <= 1'b0;
      pressR <= 1'b0;
    end else begin
      // A single matching sample breaks the run, so the count restarts
      if (!differS) begin
        cntR <= CNT_ZERO;
      end else if (flipS) begin
        cntR   <= CNT_ZERO;
        levelR <= sync2R;
      end else begin
        cntR <= cntR + CNT_ONE;
      end
      // Only the rising change pulses; release is silent
      pressR <= flipS && sync2R;
    end
  end

  assign oPress = pressR;

endmodule

// File: rtl/cpu_run_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_run_ctrl
//   Run/step/breakpoint sequencer producing a single-cycle clock enable for
//   the single-cycle core. Free-run pulses every DIV_N cycles, single-step
//   pulses once per debounced button press, and a PC breakpoint stops free-run
//   before the matching instruction executes.
//   Optional feature macro: RUN_CYCLE_CNT_EN -- when defined, oCycleCnt counts
//   oCpuEn pulses (reset value CNT_INIT, normally zero); when undefined the
//   counter is absent and oCycleCnt is tied to zero.
// Ports
//   iClk       in  1     board clock
//   iRst_n     in  1     asynchronous active-low reset
//   iMode      in  2     00 HALT, 01 RUN, 10 STEP, 11 treated as HALT
//   iStepBtn   in  1     raw bouncing step button, active-high
//   iBrkEn     in  1     breakpoint enable
//   iBrkAddr   in  PC_W  breakpoint PC
//   iPC        in  PC_W  PC of the instruction about to execute
//   oCpuEn     out 1     registered one-cycle enable to the core
//   oState     out 2     0 HALT, 1 RUN, 2 STEP, 3 BRK
//   oBrkHit    out 1     high while in BRK
//   oCycleCnt  out 32    count of oCpuEn pulses
// -----------------------------------------------------------------------------
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int DIV_N = 1_000_000,
  parameter int DEB_N = 20_000,
  parameter int PC_W  = 32
`ifdef RUN_CYCLE_CNT_EN
  ,
  parameter logic [CYCLE_CNT_W-1:0] CNT_INIT = 32'd0
`endif
) (
  input  logic                   iClk,
  input  logic                   iRst_n,
  input  logic [1:0]             iMode,
  input  logic                   iStepBtn,
  input  logic                   iBrkEn,
  input  logic [PC_W-1:0]        iBrkAddr,
  input  logic [PC_W-1:0]        iPC,
  output logic                   oCpuEn,
  output logic [1:0]             oState,
  output logic                   oBrkHit,
  output logic [CYCLE_CNT_W-1:0] oCycleCnt
);

  localparam int DIV_W = (DIV_N > 1) ? $clog2(DIV_N) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(DIV_N - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);

  state_e           stateR;
  logic             cpuEnR;
  logic             brkHitR;
  logic [DIV_W-1:0] divCntR;

  mode_e            modeS;
  logic             pressS;
  logic             tickS;
  logic             brkMatchS;
  logic             runFireS;
  logic             stepFireS;
  logic             pulseNextS;

  btn_debounce #(
    .DEB_N (DEB_N)
  ) uDebounce (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .iBtn   (iStepBtn),
    .oPress (pressS)
  );

  // Pulse decision; a tick or press only fires if the mode keeps us in place
  always_comb begin
    modeS      = mode_e'(iMode);
    tickS      = (divCntR == DIV_MAX);
    brkMatchS  = iBrkEn && (iPC == iBrkAddr);
    runFireS   = (stateR == ST_RUN)  && (modeS == MODE_RUN)  && tickS && !brkMatchS;
    stepFireS  = (stateR == ST_STEP) && (modeS == MODE_STEP) && pressS;
    pulseNextS = runFireS || stepFireS;
  end

  // Sequencer FSM with divider, enable and breakpoint flag registers
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      stateR  <= ST_HALT;
      cpuEnR  <= 1'b0;
      brkHitR <= 1'b0;
      divCntR <= DIV_ZERO;
    end else begin
      cpuEnR  <= pulseNextS;
      brkHitR <= 1'b0;
      // Divider idles at zero outside RUN, so every entry into RUN starts clean
      divCntR <= DIV_ZERO;
      case (stateR)
        ST_HALT: begin
          case (modeS)
            MODE_RUN:  stateR <= ST_RUN;
            MODE_STEP: stateR <= ST_STEP;
            default:   stateR <= ST_HALT;
          endcase
        end
        ST_RUN: begin
          case (modeS)
            MODE_RUN: begin
              if (tickS) begin
                divCntR <= DIV_ZERO;
                // Stop before the matching instruction executes: no pulse
                if (brkMatchS) begin
                  stateR  <= ST_BRK;
                  brkHitR <= 1'b1;
                end else begin
                  stateR <= ST_RUN;
                end
              end else begin
                divCntR <= divCntR + DIV_ONE;
                stateR  <= ST_RUN;
              end
            end
            MODE_STEP: stateR <= ST_STEP;
            default:   stateR <= ST_HALT;
          endcase
        end
        ST_STEP: begin
          case (modeS)
            MODE_RUN:  stateR <= ST_RUN;
            MODE_STEP: stateR <= ST_STEP;
            default:   stateR <= ST_HALT;
          endcase
        end
        ST_BRK: begin
          // RUN cannot leave BRK; the core must be stepped off the breakpoint
          case (modeS)
            MODE_RUN: begin
              stateR  <= ST_BRK;
              brkHitR <= 1'b1;
            end
            MODE_STEP: stateR <= ST_STEP;
            default:   stateR <= ST_HALT;
          endcase
        end
        default: begin
          stateR <= ST_HALT;
        end
      endcase
    end
  end

`ifdef RUN_CYCLE_CNT_EN
  logic [CYCLE_CNT_W-1:0] cycleCntR;

  // Pulse counter, updated on the same edge that raises oCpuEn
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      cycleCntR <= CNT_INIT;
    end else if (pulseNextS) begin
      cycleCntR <= cycleCntIncr(cycleCntR);
    end else begin
      cycleCntR <= cycleCntR;
    end
  end

  assign oCycleCnt = cycleCntR;
`else
  assign oCycleCnt = 32'd0;
`endif

  assign oCpuEn  = cpuEnR;
  assign oState  = stateR;
  assign oBrkHit = brkHitR;

endmodule
